// File: rtl/spi_slave_sync_if.sv
// Stream-side interface of spi_slave_sync.
//   slave  : the SPI slave (consumes TX words, produces RX command words and status pulses)
//   master : the client (trace packet source / command consumer)
// Signals:
//   tx_data/tx_valid/tx_ready : next word to transmit, valid/ready handshake
//   rx_data/rx_valid          : last received command word, 1-clk update pulse
//   tx_underrun               : 1-clk pulse, a TX word slot started with nothing held
//   frame_abort               : 1-clk pulse, frame ended before the command word completed
interface spi_slave_sync_if #(
    parameter int RX_BITS = 32,
    parameter int TX_BITS = 128
);
    logic [TX_BITS-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [RX_BITS-1:0] rx_data;
    logic               rx_valid;
    logic               tx_underrun;
    logic               frame_abort;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, frame_abort
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, frame_abort
    );
endinterface

// File: rtl/spi_slave_sync.sv
// Mode-selectable SPI slave running entirely in the clk domain.
// Cs/DClk/Rx are synchronised and edge-detected; each frame receives one RX_BITS
// command word, then streams TX_BITS words out on Tx until Cs rises.
// Ports:
//   clk, rst     : system clock, asynchronous active-low reset
//   Cs, DClk, Rx : SPI pins from the host (Cs active low)
//   Tx           : SPI data to the host
//   bus          : stream handshake interface (slave modport)
module spi_slave_sync #(
    parameter int RX_BITS     = 32,
    parameter int TX_BITS     = 128,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2,
    parameter bit FILL        = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Cs,
    input  logic            DClk,
    input  logic            Rx,
    output logic            Tx,
    spi_slave_sync_if.slave bus
);
    localparam int RXW = $clog2(RX_BITS + 1);
    localparam int TXW = $clog2(TX_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_TX} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
    logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
    logic                   cs_dly_q, cs_dly_d;
    logic                   dclk_dly_q, dclk_dly_d;

    state_e                 state_q, state_d;
    logic [RXW-1:0]         rxcnt_q, rxcnt_d;
    logic [TXW-1:0]         txcnt_q, txcnt_d;
    logic [RX_BITS-1:0]     rx_shift_q, rx_shift_d;
    logic [TX_BITS-1:0]     tx_shift_q, tx_shift_d;
    logic [RX_BITS-1:0]     rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   abort_q, abort_d;
    logic [TX_BITS-1:0]     hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;

    logic cs_s, dclk_s, rx_s;
    logic cs_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic accept, load_hold;

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], Cs};
        dclk_sync_d = {dclk_sync_q[SYNC_STAGES-2:0], DClk};
        rx_sync_d   = {rx_sync_q[SYNC_STAGES-2:0], Rx};
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        dclk_s      = dclk_sync_q[SYNC_STAGES-1];
        rx_s        = rx_sync_q[SYNC_STAGES-1];
        cs_dly_d    = cs_s;
        dclk_dly_d  = dclk_s;
        cs_fall     = cs_dly_q & ~cs_s;
        // Leading edge leaves the idle level, trailing edge returns to it.
        lead_edge   = (dclk_s != dclk_dly_q) && (dclk_dly_q == CPOL);
        trail_edge  = (dclk_s != dclk_dly_q) && (dclk_dly_q != CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
    end

    always_comb begin
        state_d    = state_q;
        rxcnt_d    = rxcnt_q;
        txcnt_d    = txcnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        abort_d    = 1'b0;
        load_hold  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_shift_d = '1;
                if (cs_fall) begin
                    state_d    = S_RX;
                    rxcnt_d    = '0;
                    txcnt_d    = '0;
                    rx_shift_d = '0;
                end
            end
            S_RX: begin
                tx_shift_d = '1;
                if (cs_s) begin
                    // Any Cs rise in RX is a short frame: either some bits
                    // arrived, or none did after Cs fell.
                    state_d    = S_IDLE;
                    abort_d    = 1'b1;
                    rxcnt_d    = '0;
                    rx_shift_d = '0;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[RX_BITS-2:0], rx_s};
                    rxcnt_d    = rxcnt_q + RXW'(1);
                    if (rxcnt_q == RXW'(RX_BITS - 1)) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        state_d    = S_TX;
                    end
                end
            end
            S_TX: begin
                if (cs_s) begin
                    state_d    = S_IDLE;
                    rxcnt_d    = '0;
                    txcnt_d    = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '1;
                end else if (shift_edge) begin
                    // Count 0 (first word) or TX_BITS (word done) starts a new slot.
                    if (txcnt_q == '0 || txcnt_q == TXW'(TX_BITS)) begin
                        txcnt_d = TXW'(1);
                        if (hold_full_q) begin
                            tx_shift_d = hold_q;
                            load_hold  = 1'b1;
                        end else begin
                            tx_shift_d = {TX_BITS{FILL}};
                            underrun_d = 1'b1;
                        end
                    end else begin
                        txcnt_d    = txcnt_q + TXW'(1);
                        tx_shift_d = {tx_shift_q[TX_BITS-2:0], 1'b1};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Accept only when empty and load only when full, so a word accepted in the
    // load clk always becomes the next word.
    always_comb begin
        accept      = bus.tx_valid & ~hold_full_q;
        hold_d      = accept ? bus.tx_data : hold_q;
        hold_full_d = accept | (hold_full_q & ~load_hold);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync_q   <= '1;
            dclk_sync_q <= {SYNC_STAGES{CPOL}};
            rx_sync_q   <= '0;
            cs_dly_q    <= 1'b1;
            dclk_dly_q  <= CPOL;
            state_q     <= S_IDLE;
            rxcnt_q     <= '0;
            txcnt_q     <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            dclk_sync_q <= dclk_sync_d;
            rx_sync_q   <= rx_sync_d;
            cs_dly_q    <= cs_dly_d;
            dclk_dly_q  <= dclk_dly_d;
            state_q     <= state_d;
            rxcnt_q     <= rxcnt_d;
            txcnt_q     <= txcnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Tx is the registered MSB of the shifter; it is all-ones outside TX words.
    assign Tx              = tx_shift_q[TX_BITS-1];
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.frame_abort = abort_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: four instances cover CPOL/CPHA modes
// 00, 01, 10, 11. Stimulus pushes expected Tx bits, rx words, and the bit
// counts at which underrun/abort/tx_ready-rise must occur; a monitor pops and
// compares whenever the active instance presents an output.
`timescale 1ns/1ps
module tb_spi_slave_sync;
    localparam int RXB  = 32;
    localparam int TXB  = 128;
    localparam int SYNC = 2;
    localparam int HALF = SYNC + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] cs = 4'hF;
    logic [3:0] dclk = 4'b1100;
    logic [3:0] rxp = 4'h0;
    logic [3:0] txp;
    logic [3:0] tvalid = 4'h0;
    logic [TXB-1:0] tdata = '0;
    logic [3:0] rdy, rxv, und, abt;
    logic [RXB-1:0] rxd [4];
    logic [1:0] act = 2'd0;

    int n_chk = 0;
    int n_err = 0;

    logic           exp_tx  [$];
    logic [RXB-1:0] exp_rx  [$];
    int             exp_und [$];
    int             exp_abt [$];
    int             exp_rdy [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_m
        spi_slave_sync_if #(.RX_BITS(RXB), .TX_BITS(TXB)) u_if ();
        assign u_if.tx_data  = tdata;
        assign u_if.tx_valid = tvalid[g];
        assign rdy[g] = u_if.tx_ready;
        assign rxv[g] = u_if.rx_valid;
        assign und[g] = u_if.tx_underrun;
        assign abt[g] = u_if.frame_abort;
        assign rxd[g] = u_if.rx_data;
        spi_slave_sync #(
            .RX_BITS(RXB), .TX_BITS(TXB), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)),
            .SYNC_STAGES(SYNC), .FILL(1'b1)
        ) u_dut (
            .clk(clk), .rst(rst_n), .Cs(cs[g]), .DClk(dclk[g]), .Rx(rxp[g]),
            .Tx(txp[g]), .bus(u_if)
        );
    end

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic miss(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: event with no expectation (or timeout)", nm);
    endtask

    task automatic hwait();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic push_ones(input int n);
        for (int i = 0; i < n; i++) exp_tx.push_back(1'b1);
    endtask

    task automatic push_word(input logic [TXB-1:0] w, input int nb);
        for (int i = 0; i < nb; i++) exp_tx.push_back(w[TXB-1-i]);
    endtask

    task automatic offer(input logic [TXB-1:0] w);
        int n = 0;
        while (!rdy[0] && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy[0]) begin
            miss("offer_timeout");
            return;
        end
        tdata = w;
        tvalid[0] = 1'b1;
        @(posedge clk);
        #1;
        tvalid[0] = 1'b0;
    endtask

    // Host master. In CPHA=0 the final trailing edge coincides with Cs rise so
    // no further word slot starts. rst_at >= 0 resets the DUT before that bit.
    task automatic spi_frame(input int m, input logic [RXB-1:0] cmd, input int nbits,
                             input int rst_at);
        logic [1:0] mm = 2'(m);
        logic cpol = mm[1];
        logic cpha = mm[0];
        logic b;
        cs[m] = 1'b0;
        hwait();
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                offer('0);
                chk("ready_full", 128'(rdy[0]), 128'(0));
                rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_tx", 128'(txp[0]), 128'(1));
                chk("rst_ready", 128'(rdy[0]), 128'(1));
                chk("rst_rxdata", 128'(rxd[0]), 128'(0));
                chk("rst_pulses", 128'({rxv[0], und[0], abt[0]}), 128'(0));
                cs[m] = 1'b1;
                dclk[m] = cpol;
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                hwait();
                return;
            end
            b = (i < RXB) ? cmd[RXB-1-i] : 1'b0;
            if (!cpha) begin
                rxp[m] = b;
                hwait();
                dclk[m] = ~cpol;
                hwait();
                dclk[m] = cpol;
                if (i == nbits - 1) cs[m] = 1'b1;
            end else begin
                dclk[m] = ~cpol;
                rxp[m] = b;
                hwait();
                dclk[m] = cpol;
                hwait();
            end
        end
        if (cpha) cs[m] = 1'b1;
        hwait();
        hwait();
    endtask

    task automatic monitor();
        logic [3:0] cs_p, dk_p, rdy_p;
        logic cp, ph, lead, trail;
        int bitcnt = 0;
        cs_p = 4'hF;
        dk_p = 4'b1100;
        rdy_p = 4'hF;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cp = act[1];
                ph = act[0];
                if (cs_p[act] && !cs[act]) bitcnt = 0;
                if (!cs[act]) begin
                    lead  = (dk_p[act] == cp) && (dclk[act] != cp);
                    trail = (dk_p[act] != cp) && (dclk[act] == cp);
                    if (ph ? trail : lead) begin
                        if (exp_tx.size() == 0) miss("tx_bit");
                        else chk($sformatf("tx_bit%0d", bitcnt), 128'(txp[act]), 128'(exp_tx.pop_front()));
                        bitcnt++;
                    end
                end
                if (rxv[act]) begin
                    if (exp_rx.size() == 0) miss("rx_valid");
                    else chk("rx_data", 128'(rxd[act]), 128'(exp_rx.pop_front()));
                end
                if (und[act]) begin
                    if (exp_und.size() == 0) miss("tx_underrun");
                    else chk("underrun_bit", 128'(bitcnt), 128'(exp_und.pop_front()));
                end
                if (abt[act]) begin
                    if (exp_abt.size() == 0) miss("frame_abort");
                    else chk("abort_bit", 128'(bitcnt), 128'(exp_abt.pop_front()));
                end
                if (rdy[act] && !rdy_p[act]) begin
                    if (exp_rdy.size() == 0) miss("tx_ready_rise");
                    else chk("ready_rise_bit", 128'(bitcnt), 128'(exp_rdy.pop_front()));
                end
            end
            cs_p = cs;
            dk_p = dclk;
            rdy_p = rdy;
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                #2ms;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", 128'(txp[0]), 128'(1));
        chk("reset_ready", 128'(rdy[0]), 128'(1));
        chk("reset_rxdata", 128'(rxd[0]), 128'(0));
        chk("reset_pulses", 128'({rxv[0], und[0], abt[0]}), 128'(0));

        // Mode 0 command receive, Tx idle high throughout.
        act = 2'd0;
        push_ones(32);
        exp_rx.push_back(32'hA5A5_1234);
        spi_frame(0, 32'hA5A5_1234, 32, -1);

        // One held word, then FILL with a single underrun at bit 160.
        offer(128'h0123456789ABCDEF0123456789ABCDEF);
        chk("ready_after_offer", 128'(rdy[0]), 128'(0));
        push_ones(32);
        push_word(128'h0123456789ABCDEF0123456789ABCDEF, 128);
        push_ones(128);
        exp_rx.push_back(32'h1357_9BDF);
        exp_rdy.push_back(32);
        exp_und.push_back(160);
        spi_frame(0, 32'h1357_9BDF, 288, -1);

        // Back-to-back: three words, 384 contiguous bits, no underrun.
        offer(128'hDEADBEEF_00000000_FFFFFFFF_12345678);
        push_ones(32);
        push_word(128'hDEADBEEF_00000000_FFFFFFFF_12345678, 128);
        push_word(128'h55555555_AAAAAAAA_0F0F0F0F_F0F0F0F0, 128);
        push_word(128'h80000000_00000000_00000000_00000001, 128);
        exp_rx.push_back(32'hCAFE_F00D);
        exp_rdy.push_back(32);
        exp_rdy.push_back(160);
        exp_rdy.push_back(288);
        fork
            spi_frame(0, 32'hCAFE_F00D, 416, -1);
            begin
                offer(128'h55555555_AAAAAAAA_0F0F0F0F_F0F0F0F0);
                offer(128'h80000000_00000000_00000000_00000001);
            end
        join

        // Abort after 17 bits; rx_data kept, next frame fine.
        push_ones(17);
        exp_abt.push_back(17);
        spi_frame(0, 32'h0000_FFFF, 17, -1);
        chk("abort_rxdata_kept", 128'(rxd[0]), 128'(32'hCAFE_F00D));
        chk("abort_tx_idle", 128'(txp[0]), 128'(1));
        push_ones(32);
        exp_rx.push_back(32'h0F1E_2D3C);
        spi_frame(0, 32'h0F1E_2D3C, 32, -1);

        // Other SPI modes.
        for (int m = 1; m < 4; m++) begin
            act = 2'(m);
            push_ones(32);
            exp_rx.push_back(32'hA5A5_1234);
            spi_frame(m, 32'hA5A5_1234, 32, -1);
        end

        // Reset during TX with a word held; fresh frame must underrun (holding empty).
        act = 2'd0;
        offer(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F);
        push_ones(32);
        push_word(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 8);
        exp_rdy.push_back(32);
        exp_rx.push_back(32'h2468_ACE0);
        spi_frame(0, 32'h2468_ACE0, 72, 40);
        push_ones(40);
        exp_und.push_back(32);
        exp_rx.push_back(32'h1111_8888);
        spi_frame(0, 32'h1111_8888, 40, -1);

        repeat (20) @(posedge clk);
        #1;
        chk("left_tx", 128'(exp_tx.size()), 128'(0));
        chk("left_rx", 128'(exp_rx.size()), 128'(0));
        chk("left_und", 128'(exp_und.size()), 128'(0));
        chk("left_abt", 128'(exp_abt.size()), 128'(0));
        chk("left_rdy", 128'(exp_rdy.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
